// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-cold column drive, 2-flop row synchronizer,
// per-frame contact classification and a frame-based press/release debouncer.
module keypad_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       IsPressed,
    output logic [3:0] keyboard_data,
    output logic       key_valid
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int FCNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(DEBOUNCE_SCANS);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);
    localparam bit ONE_SHOT = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic [3:0]       acc_code_q, acc_code_d;

    state_t           state_q;
    logic [3:0]       cand_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic             pressed_q, valid_q;
    logic [3:0]       data_q;

    logic             sample, frame_done, frame_key, frame_none, same_key;
    logic [2:0]       col_hits, hit_sum;
    logic [3:0]       col_code, tot_code;
    logic [1:0]       tot_cnt;
    logic [FCNT_W-1:0] fcnt_inc;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Contacts are accumulated across the sweep and saturate at 2, which is all MULTI needs.
    always_comb begin
        sample   = (div_q == DIV_LAST);
        div_d    = sample ? '0 : div_q + 1'b1;
        col_d    = sample ? col_q + 2'd1 : col_q;
        col_hits = '0;
        col_code = '0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = key_code(2'(r), col_q);
            end
        end
        hit_sum    = {1'b0, acc_cnt_q} + col_hits;
        tot_cnt    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_code   = (acc_cnt_q != 2'd0) ? acc_code_q : col_code;
        frame_done = sample && (col_q == 2'd3);
        frame_key  = frame_done && (tot_cnt == 2'd1);
        frame_none = frame_done && (tot_cnt == 2'd0);
        same_key   = frame_key && (tot_code == cand_q);
        fcnt_inc   = (fcnt_q >= FCNT_MAX) ? FCNT_MAX : fcnt_q + 1'b1;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (frame_done) begin
            acc_cnt_d  = '0;
            acc_code_d = '0;
        end else if (sample) begin
            acc_cnt_d  = tot_cnt;
            acc_code_d = tot_code;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            div_q      <= '0;
            col_q      <= '0;
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
            div_q      <= div_d;
            col_q      <= col_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Debouncer only moves on frame results; a different key while held never rolls over.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            fcnt_q    <= '0;
            pressed_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (frame_done) begin
                case (state_q)
                    IDLE: begin
                        if (frame_key) begin
                            cand_q <= tot_code;
                            fcnt_q <= FCNT_ONE;
                            if (ONE_SHOT) begin
                                state_q   <= PRESSED;
                                data_q    <= tot_code;
                                pressed_q <= 1'b1;
                                valid_q   <= 1'b1;
                            end else begin
                                state_q <= CAND;
                            end
                        end
                    end
                    CAND: begin
                        if (same_key) begin
                            fcnt_q <= fcnt_inc;
                            if (fcnt_inc == FCNT_MAX) begin
                                state_q   <= PRESSED;
                                data_q    <= cand_q;
                                pressed_q <= 1'b1;
                                valid_q   <= 1'b1;
                            end
                        end else if (frame_key) begin
                            cand_q <= tot_code;
                            fcnt_q <= FCNT_ONE;
                        end else begin
                            state_q <= IDLE;
                            fcnt_q  <= '0;
                        end
                    end
                    PRESSED: begin
                        if (frame_none) begin
                            fcnt_q <= FCNT_ONE;
                            if (ONE_SHOT) begin
                                state_q   <= IDLE;
                                pressed_q <= 1'b0;
                            end else begin
                                state_q <= REL;
                            end
                        end else if (!same_key) begin
                            state_q <= REL;
                            fcnt_q  <= '0;
                        end
                    end
                    REL: begin
                        if (frame_none) begin
                            fcnt_q <= fcnt_inc;
                            if (fcnt_inc == FCNT_MAX) begin
                                state_q   <= IDLE;
                                pressed_q <= 1'b0;
                            end
                        end else if (same_key) begin
                            state_q <= PRESSED;
                        end else begin
                            fcnt_q <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign col_out       = ~(4'b0001 << col_q);
    assign IsPressed     = pressed_q;
    assign keyboard_data = data_q;
    assign key_valid     = valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model drives rows from col_out,
// expected press/release events are queued and checked by a separate monitor.
module tb_keypad_scan;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       IsPressed;
    logic [3:0] keyboard_data;
    logic       key_valid;

    logic [15:0] keys;
    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       is_press;
        logic [3:0] code;
    } event_t;
    event_t exp_q[$];

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .row_in(row_in), .col_out(col_out),
        .IsPressed(IsPressed), .keyboard_data(keyboard_data), .key_valid(key_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // keys bit index is row*4+col; a held key pulls its row low while its column is driven
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitFrames(input int n);
        logic [3:0] p;
        bit found;
        for (int f = 0; f < n; f++) begin
            p = col_out;
            found = 0;
            for (int k = 0; k < 40 && !found; k++) begin
                @(negedge sys_clk);
                if (col_out == 4'b1110 && p == 4'b0111) found = 1;
                p = col_out;
            end
            if (!found) checkOutput("frame_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, input int frames);
        keys = k;
        waitFrames(frames);
    endtask

    task automatic expectPress(input logic [3:0] code);
        exp_q.push_back('{is_press: 1'b1, code: code});
    endtask

    task automatic expectRelease();
        exp_q.push_back('{is_press: 1'b0, code: 4'h0});
    endtask

    // Monitor: every key_valid pulse and every IsPressed fall is matched against the queue
    logic prev_pressed = 1'b0;
    always @(negedge sys_clk) begin
        event_t e;
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_press", {28'd0, keyboard_data}, 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_is_press", 32'd1, {31'd0, e.is_press});
                checkOutput("press_code", {28'd0, keyboard_data}, {28'd0, e.code});
            end
        end
        if (prev_pressed && !IsPressed) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_release", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_is_release", 32'd0, {31'd0, e.is_press});
            end
        end
        prev_pressed = IsPressed;
    end

    initial begin
        keys    = '0;
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_col_out", {28'd0, col_out}, 32'hE);
        checkOutput("rst_pressed", {31'd0, IsPressed}, 32'd0);
        checkOutput("rst_data", {28'd0, keyboard_data}, 32'd0);
        checkOutput("rst_valid", {31'd0, key_valid}, 32'd0);
        sys_rst = 1'b0;

        waitFrames(1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("col_seq", {28'd0, col_out}, {28'd0, ~(4'b0001 << (i / 4))});
            @(negedge sys_clk);
        end
        waitFrames(9);
        checkOutput("idle_pressed", {31'd0, IsPressed}, 32'd0);

        expectPress(4'h5);
        applyStimulus(16'h0020, 6);
        checkOutput("k5_held", {31'd0, IsPressed}, 32'd1);
        checkOutput("k5_data", {28'd0, keyboard_data}, 32'h5);
        expectRelease();
        applyStimulus(16'h0000, 2);
        checkOutput("k5_rel_pending", {31'd0, IsPressed}, 32'd1);
        waitFrames(4);
        checkOutput("k5_released", {31'd0, IsPressed}, 32'd0);
        checkOutput("k5_data_hold", {28'd0, keyboard_data}, 32'h5);

        for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 16'h0008 : 16'h0000, 1);
        checkOutput("bounce_no_press", {31'd0, IsPressed}, 32'd0);
        expectPress(4'hA);
        applyStimulus(16'h0008, 3);
        checkOutput("kA_data", {28'd0, keyboard_data}, 32'hA);
        expectRelease();
        applyStimulus(16'h0000, 4);

        applyStimulus(16'h0003, 5);
        checkOutput("multi_not_pressed", {31'd0, IsPressed}, 32'd0);
        expectPress(4'h1);
        applyStimulus(16'h0001, 3);
        checkOutput("k1_pressed", {31'd0, IsPressed}, 32'd1);
        expectRelease();
        applyStimulus(16'h0000, 4);

        expectPress(4'hC);
        applyStimulus(16'h0800, 4);
        applyStimulus(16'h0100, 5);
        checkOutput("rollover_pressed", {31'd0, IsPressed}, 32'd1);
        checkOutput("rollover_data", {28'd0, keyboard_data}, 32'hC);
        expectRelease();
        applyStimulus(16'h0000, 3);
        checkOutput("kC_released", {31'd0, IsPressed}, 32'd0);
        expectPress(4'h7);
        applyStimulus(16'h0100, 4);
        expectRelease();
        applyStimulus(16'h0000, 4);

        expectPress(4'h3);
        applyStimulus(16'h0004, 4);
        repeat (5) @(negedge sys_clk);
        expectRelease();
        #1 sys_rst = 1'b1;
        #1;
        checkOutput("midrst_col_out", {28'd0, col_out}, 32'hE);
        checkOutput("midrst_pressed", {31'd0, IsPressed}, 32'd0);
        checkOutput("midrst_data", {28'd0, keyboard_data}, 32'd0);
        checkOutput("midrst_valid", {31'd0, key_valid}, 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        expectPress(4'h3);
        waitFrames(3);
        checkOutput("k3_repressed", {31'd0, IsPressed}, 32'd1);
        checkOutput("k3_data", {28'd0, keyboard_data}, 32'h3);
        expectRelease();
        applyStimulus(16'h0000, 4);

        repeat (4) @(negedge sys_clk);
        checkOutput("events_outstanding", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
